booth_divider: RTL and testbench

- Sequential signed two's-complement divider; the inverse operation to the team's Booth multiplier, sharing the same operand width.
- Takes dividend and divisor, runs one restoring-division step per clock on operand magnitudes, then applies sign correction.
- Returns quotient and remainder with status flags.
- Sits beside the multiplier in the lab arithmetic datapath with a start/done handshake.

---
 rtl/booth_arith_pkg.sv | 14 +
 rtl/div_step.sv | 24 ++
 rtl/booth_divider.sv | 134 +++++++++++++
 tb/tb_booth_divider.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_arith_pkg.sv
// Shared arithmetic constants for the Booth multiplier/divider pair.
// Holds the common operand width and the divider's state encoding.
package booth_arith_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes: shift {rem,quo}, trial-subtract, restore.
// Purely combinational; no handshake of its own.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH:0]   i_dmag,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // Partial remainder stays below |divisor| <= 2^(WIDTH-1), so WIDTH bits hold it
  // and the shifted value plus a sign bit fits in WIDTH+1 bits.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_trial = w_shift - i_dmag;

  assign o_rem = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider, one restoring step per clock, start/done handshake.
// done pulses WIDTH+2 cycles after the accepted start; start is ignored unless idle.
module booth_divider
  import booth_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH:0]   r_dmag;
  logic [WIDTH-1:0] r_dvd;
  logic             r_dsr_neg;
  logic             r_dz;
  logic             r_ovf;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH:0]   w_dsr_ext;
  logic [WIDTH:0]   w_dsr_mag;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic             w_dz;
  logic             w_ovf;

  // |most-negative| is 2^(WIDTH-1), which still fits WIDTH unsigned bits for the dividend.
  assign w_dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign w_dsr_ext = {divisor[WIDTH-1], divisor};
  assign w_dsr_mag = divisor[WIDTH-1] ? (~w_dsr_ext + 1'b1) : w_dsr_ext;
  assign w_dz      = (divisor == '0);
  assign w_ovf     = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_quo  (r_quo),
    .i_dmag (r_dmag),
    .o_rem  (w_rem_next),
    .o_quo  (w_quo_next)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_CALC;
      S_CALC:  if (r_count == CW'(1)) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dmag      <= '0;
      r_dvd       <= '0;
      r_dsr_neg   <= 1'b0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      // Handshake outputs trail the state register by one cycle.
      busy <= (r_state != S_IDLE);
      done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd       <= dividend;
            r_dsr_neg   <= divisor[WIDTH-1];
            r_dmag      <= w_dsr_mag;
            r_rem       <= '0;
            r_quo       <= w_dvd_mag;
            r_count     <= CW'(WIDTH);
            r_dz        <= w_dz;
            r_ovf       <= w_ovf;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        S_CALC: begin
          r_rem   <= w_rem_next;
          r_quo   <= w_quo_next;
          r_count <= r_count - CW'(1);
        end
        S_FIX: begin
          // Zero divisor ignores the iteration result entirely.
          if (r_dz) begin
            r_quo <= '1;
            r_rem <= r_dvd;
          end else begin
            if (r_dvd[WIDTH-1] ^ r_dsr_neg) r_quo <= ~r_quo + 1'b1;
            if (r_dvd[WIDTH-1])             r_rem <= ~r_rem + 1'b1;
          end
        end
        S_DONE: begin
          quotient    <= r_quo;
          remainder   <= r_rem;
          div_by_zero <= r_dz;
          overflow    <= r_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider at WIDTH=4 against an integer-arithmetic model.
module tb_booth_divider;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         overflow;

  int checks = 0;
  int failures = 0;

  booth_divider #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz, output logic ov);
    int sa, sb, iq, ir;
    sa = int'($signed(a));
    sb = int'($signed(b));
    dz = 1'b0;
    ov = 1'b0;
    if (sb == 0) begin
      iq = -1; ir = sa; dz = 1'b1;
    end else if (sa == -(1 << (W-1)) && sb == -1) begin
      iq = sa; ir = 0; ov = 1'b1;
    end else begin
      iq = sa / sb; ir = sa % sb;
    end
    q = W'(iq);
    r = W'(ir);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz, output logic ov,
                        output int lat, output int bcnt);
    @(negedge clock);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clock);
    #1 start = 1'b0;
    lat = 0; bcnt = 0; q = 'x; r = 'x; dz = 1'bx; ov = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if (busy) bcnt++;
      if (done) begin
        lat = i; q = quotient; r = remainder; dz = div_by_zero; ov = overflow;
        break;
      end
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r, eq, er;
    logic dz, ov, edz, eov;
    int lat, bcnt;
    model(a, b, eq, er, edz, eov);
    run_op(a, b, q, r, dz, ov, lat, bcnt);
    checks++;
    if ({q, r, dz, ov} !== {eq, er, edz, eov}) begin
      failures++;
      $display("FAIL %s %0d/%0d: got q=%h r=%h dz=%b ov=%b, want q=%h r=%h dz=%b ov=%b",
               name, $signed(a), $signed(b), q, r, dz, ov, eq, er, edz, eov);
    end
    checks++;
    if (lat !== W + 2) begin
      failures++;
      $display("FAIL %s_latency: got %0d, want %0d", name, lat, W + 2);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dz=%b ov=%b, want all 0",
               quotient, remainder, busy, done, div_by_zero, overflow);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] q, r;
    logic dz, ov;
    int lat, bcnt;
    run_op(4'd7, 4'd2, q, r, dz, ov, lat, bcnt);
    checks++;
    if ({q, r, dz, ov} !== {4'd3, 4'd1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL basic_7_2: got q=%h r=%h dz=%b ov=%b, want q=3 r=1 dz=0 ov=0", q, r, dz, ov);
    end
    checks++;
    if (lat !== 6) begin
      failures++;
      $display("FAIL basic_latency: got %0d, want 6", lat);
    end
    checks++;
    if (bcnt !== 6) begin
      failures++;
      $display("FAIL basic_busy_cycles: got %0d, want 6", bcnt);
    end
    @(posedge clock); #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL basic_after_done: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_signed();
    logic [W-1:0] q, r;
    logic dz, ov;
    int lat, bcnt;
    logic [W-1:0] ta [3] = '{4'h9, 4'h7, 4'h8};
    logic [W-1:0] tb [3] = '{4'h2, 4'hE, 4'h2};
    logic [W-1:0] tq [3] = '{4'hD, 4'hD, 4'hC};
    logic [W-1:0] tr [3] = '{4'hF, 4'h1, 4'h0};
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], q, r, dz, ov, lat, bcnt);
      checks++;
      if ({q, r, dz, ov} !== {tq[i], tr[i], 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL signed_%0d: got q=%h r=%h dz=%b ov=%b, want q=%h r=%h dz=0 ov=0",
                 i, q, r, dz, ov, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r;
    logic dz, ov;
    int lat, bcnt;
    run_op(4'd6, 4'd0, q, r, dz, ov, lat, bcnt);
    checks++;
    if ({q, r, dz, ov, lat} !== {4'hF, 4'h6, 1'b1, 1'b0, 32'd6}) begin
      failures++;
      $display("FAIL div_zero: got q=%h r=%h dz=%b ov=%b lat=%0d, want q=f r=6 dz=1 ov=0 lat=6",
               q, r, dz, ov, lat);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] q, r;
    logic dz, ov;
    int lat, bcnt;
    run_op(4'h8, 4'hF, q, r, dz, ov, lat, bcnt);
    checks++;
    if ({q, r, dz, ov} !== {4'h8, 4'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL overflow: got q=%h r=%h dz=%b ov=%b, want q=8 r=0 dz=0 ov=1", q, r, dz, ov);
    end
    run_op(4'd3, 4'd3, q, r, dz, ov, lat, bcnt);
    checks++;
    if ({q, r, dz, ov} !== {4'h1, 4'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL overflow_cleared: got q=%h r=%h dz=%b ov=%b, want q=1 r=0 dz=0 ov=0", q, r, dz, ov);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      check_op("random", W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
  endtask

  task automatic test_start_while_busy();
    int ndone = 0;
    logic [W-1:0] q = 'x, r = 'x;
    @(negedge clock);
    start = 1'b1; dividend = 4'd7; divisor = 4'd7;
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    start = 1'b1; dividend = 4'd5; divisor = 4'd1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clock); #1;
      if (done) begin
        ndone++; q = quotient; r = remainder;
      end
    end
    checks++;
    if (ndone !== 1) begin
      failures++;
      $display("FAIL busy_ignore_done_count: got %0d, want 1", ndone);
    end
    checks++;
    if ({q, r} !== {4'd1, 4'd0}) begin
      failures++;
      $display("FAIL busy_ignore_result: got q=%h r=%h, want q=1 r=0", q, r);
    end
    check_op("after_busy", 4'd5, 4'd1);
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    int last = 0;
    int bad_gap = 0;
    int bad_val = 0;
    @(negedge clock);
    start = 1'b1; dividend = 4'd7; divisor = 4'd2;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clock); #1;
      if (done) begin
        ndone++;
        if (i - last !== W + 3) bad_gap++;
        if ({quotient, remainder} !== {4'd3, 4'd1}) bad_val++;
        last = i;
      end
    end
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (ndone !== 4 || bad_gap !== 0 || bad_val !== 0) begin
      failures++;
      $display("FAIL back_to_back: got dones=%0d bad_gaps=%0d bad_values=%0d, want 4 0 0",
               ndone, bad_gap, bad_val);
    end
    repeat (12) @(posedge clock);
  endtask

  task automatic test_reset_midop();
    int ndone = 0;
    @(negedge clock);
    start = 1'b1; dividend = 4'd7; divisor = 4'd2;
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_midop: got q=%h r=%h busy=%b done=%b dz=%b ov=%b, want all 0",
               quotient, remainder, busy, done, div_by_zero, overflow);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_midop_no_done: got dones=%0d busy=%b, want 0 0", ndone, busy);
    end
    check_op("after_reset", 4'd7, 4'd2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
